nfca_rx_bitparser: RTL

Parametrised ISO14443A PICC-to-PCD bit parser. It sits between the RX DSP (ASK envelope samples at 2.5425 Msps) and the frame/byte assembler in nfca_controller. It classifies half-bit sample windows and detects start of communication (S). It then emits Manchester-decoded bits and terminates the frame on E, collision, noise or an optional length overflow. Window length, thresholds and bit-counter width are parameters, and the block adds a delivered-bit counter.

---
 rtl/nfca_rx_bitparser.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nfca_rx_bitparser.sv
// ISO14443A PICC-to-PCD bit parser: half-bit window classification, S detection, Manchester decode.
// Optional frame length limit enabled by defining NFCA_RX_MAXLEN_EN.
module nfca_rx_bitparser #(
  parameter int HB       = 12,
  parameter int ONE_TH   = 3,
  parameter int ZERO_TH  = 1,
  parameter int CW       = 12,
  parameter int MAX_BITS = 4095
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_on,
  input  logic          rx_ask_en,
  input  logic          rx_ask,
  output logic          rx_bit_en,
  output logic          rx_bit,
  output logic          rx_end,
  output logic          rx_end_col,
  output logic          rx_end_err,
  output logic [CW-1:0] rx_bit_cnt
);

  localparam int HW = 4 * HB;
  localparam int PW = $clog2(2 * HB);
  localparam int SW = $clog2(HB + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * HB - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARSE = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;

`ifdef NFCA_RX_MAXLEN_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);
`else
  localparam logic [CW-1:0] CNT_SAT = '1;
`endif

  generate
    if (ZERO_TH >= ONE_TH || ONE_TH > HB || MAX_BITS > 2**CW - 1) begin : g_bad_params
      $error("nfca_rx_bitparser: inconsistent parameters");
    end
  endgenerate

  logic [HW-1:0] r_hist;
  logic [3:0]    r_one;
  logic [3:0]    r_zero;
  logic [1:0]    r_state;
  logic [PW-1:0] r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_bit_en;
  logic          r_bit;
  logic          r_end;
  logic          r_col;
  logic          r_err;

  logic [3:0]    w_one_next;
  logic [3:0]    w_zero_next;
  logic          w_noise;
  logic          w_sof;
  logic          w_active;

  // Window 0 holds the newest HB samples (low bits of the history).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      logic [SW-1:0] w_sum;
      always_comb begin
        w_sum = '0;
        for (int i = 0; i < HB; i++) begin
          w_sum = w_sum + SW'(r_hist[gi*HB + i]);
        end
      end
      assign w_one_next[gi]  = (w_sum >= SW'(ONE_TH));
      assign w_zero_next[gi] = (w_sum <= SW'(ZERO_TH));
    end
  endgenerate

  // A window that is neither loaded nor unloaded is ambiguous.
  assign w_noise  = |(r_one ~^ r_zero);
  assign w_sof    = (r_one == 4'b0010) && (r_zero == 4'b1101);
  assign w_active = rx_ask_en && (r_state != S_STOP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= '0;
      r_one  <= '0;
      r_zero <= '0;
    end else if (!rx_on) begin
      r_hist <= '0;
      r_one  <= '0;
      r_zero <= '0;
    end else if (w_active) begin
      r_one  <= w_one_next;
      r_zero <= w_zero_next;
      r_hist <= {r_hist[HW-2:0], rx_ask};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_cnt    <= '0;
      r_bit_en <= 1'b0;
      r_bit    <= 1'b0;
      r_end    <= 1'b0;
      r_col    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_bit_en <= 1'b0;
      r_bit    <= 1'b0;
      r_end    <= 1'b0;
      r_col    <= 1'b0;
      r_err    <= 1'b0;
      if (!rx_on) begin
        r_state <= S_IDLE;
        r_phase <= '0;
        r_cnt   <= '0;
      end else if (rx_ask_en) begin
        case (r_state)
          S_IDLE: begin
            r_phase <= '0;
            if (w_sof) begin
              r_state <= S_PARSE;
            end
          end
          S_PARSE: begin
            if (r_phase == PH_LAST) begin
              r_phase <= '0;
              if (w_noise) begin
                r_end   <= 1'b1;
                r_err   <= 1'b1;
                r_state <= S_STOP;
              end else if (r_one[1:0] == 2'b00) begin
                r_end   <= 1'b1;
                r_state <= S_STOP;
              end else if (r_one[1:0] == 2'b11) begin
                r_end   <= 1'b1;
                r_col   <= 1'b1;
                r_state <= S_STOP;
              end else begin
`ifdef NFCA_RX_MAXLEN_EN
                if (r_cnt >= CNT_MAX) begin
                  r_end   <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_bit_en <= 1'b1;
                  r_bit    <= r_one[1];
                  r_cnt    <= r_cnt + 1'b1;
                end
`else
                r_bit_en <= 1'b1;
                r_bit    <= r_one[1];
                if (r_cnt != CNT_SAT) begin
                  r_cnt <= r_cnt + 1'b1;
                end
`endif
              end
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
          S_STOP: begin
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_bit_en  = r_bit_en;
  assign rx_bit     = r_bit;
  assign rx_end     = r_end;
  assign rx_end_col = r_col;
  assign rx_end_err = r_err;
  assign rx_bit_cnt = r_cnt;

endmodule
